// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the stage sequencer and the core-level decode.
// Optional performance counters are built only when STAGE_SEQ_PERF_CNT_EN is defined.
package stage_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_MEM = 2'd2,
      HALTED   = 2'd3
   } seq_state_t;

   localparam int DEF_NUM_STAGES = 5;
   localparam int DEF_MEM_STAGE  = 3;
   localparam int DEF_CNT_W      = 32;

   // MMIO map shared with the core-level address decode
   localparam logic [31:0] MMIO_UART_DATA   = 32'h1000_0000;
   localparam logic [31:0] MMIO_UART_STATUS = 32'h1000_0004;
   localparam logic [31:0] MMIO_CYCLE_CNT   = 32'h1000_0008;

endpackage

// File: rtl/stage_seq_if.sv
// Memory-stage handshake between the stage sequencer and data memory / MMIO.
// Handshake: a transfer completes in any cycle where mem_valid and mem_ready are both
// high; once raised, mem_valid holds until that cycle, and mem_ready alone means nothing.
interface stage_seq_if;
   logic mem_valid;
   logic mem_ready;

   modport master (output mem_valid, input mem_ready);
   modport slave  (input mem_valid, output mem_ready);
endinterface

// File: rtl/stage_seq_perf.sv
// Active-cycle, retired-instruction and memory-stall counters; wrap modulo 2^CNT_W.
module stage_seq_perf
   import stage_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active,
   input  logic             retire,
   input  logic             stall,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (active) cycle_cnt   <= cycle_cnt + CNT_W'(1);
         if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
         if (stall)  stall_cnt   <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot stage sequencer for the multi-cycle core with a memory-stage valid/ready stall.
// Define STAGE_SEQ_PERF_CNT_EN to build the cycle/instret/stall counters; otherwise they read 0.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int MEM_STAGE  = DEF_MEM_STAGE,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          is_halt,
   input  logic                          mem_req,
   stage_seq_if.master                   mem,
   output logic [NUM_STAGES-1:0]         stage_en,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          retire,
   output logic                          halted,
   output logic [CNT_W-1:0]              cycle_cnt,
   output logic [CNT_W-1:0]              instret_cnt,
   output logic [CNT_W-1:0]              stall_cnt,
   output seq_state_t                    dbg_state
);

   localparam int IDX_W = $clog2(NUM_STAGES);
   localparam logic [NUM_STAGES-1:0] FIRST_EN = NUM_STAGES'(1);

   seq_state_t              state, state_nxt;
   logic [NUM_STAGES-1:0]   en_nxt;
   logic [IDX_W-1:0]        idx_nxt;
   logic                    mem_valid;
   logic                    mem_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stage_en  <= '0;
         stage_idx <= '0;
      end else begin
         state     <= state_nxt;
         stage_en  <= en_nxt;
         stage_idx <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      en_nxt    = stage_en;
      idx_nxt   = stage_idx;
      case (state)
         IDLE: begin
            if (run) begin
               state_nxt = RUN;
               en_nxt    = FIRST_EN;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            if (retire) begin
               idx_nxt = '0;
               // halt wins over run; run alone restarts stage 0 with no bubble
               if (is_halt) begin
                  state_nxt = HALTED;
                  en_nxt    = '0;
               end else if (run) begin
                  en_nxt    = FIRST_EN;
               end else begin
                  state_nxt = IDLE;
                  en_nxt    = '0;
               end
            end else if (mem_hold) begin
               state_nxt = WAIT_MEM;
            end else begin
               en_nxt  = stage_en << 1;
               idx_nxt = stage_idx + IDX_W'(1);
            end
         end
         WAIT_MEM: begin
            // a withdrawn request releases the stage rather than waiting forever
            if (!mem_hold) begin
               state_nxt = RUN;
               en_nxt    = stage_en << 1;
               idx_nxt   = stage_idx + IDX_W'(1);
            end
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt = IDLE;
            en_nxt    = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      mem_valid = stage_en[MEM_STAGE] & mem_req;
      mem_hold  = mem_valid & ~mem.mem_ready;
      retire    = stage_en[NUM_STAGES-1];
      halted    = (state == HALTED);
   end

   assign mem.mem_valid = mem_valid;
   assign dbg_state     = state;

`ifdef STAGE_SEQ_PERF_CNT_EN
   logic active;
   assign active = (state == RUN) || (state == WAIT_MEM);

   stage_seq_perf #(.CNT_W(CNT_W)) u_perf (
      .clk         (clk),
      .rst         (rst),
      .active      (active),
      .retire      (retire),
      .stall       (mem_hold),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt),
      .stall_cnt   (stall_cnt)
   );
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
   assign stall_cnt   = '0;
`endif

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the fixed 5-phase one-hot rotation that clocks fetch/decode/execute/memory/write in the multi-cycle RV32I core.
- Generates one-hot stage enables for NUM_STAGES stages.
- Stalls the memory stage on a valid/ready handshake, so variable-latency data memory and MMIO (UART, hardware counter) are supported.
- Handles run/halt control and retire signalling; sits at core top level beside the stage modules.

Parameters:
- NUM_STAGES, 5, number of stages; legal range 2..16.
- MEM_STAGE, 3, index of the stage that may wait on the memory handshake; must be < NUM_STAGES-1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- run  input  1  start/continue request.
- is_halt  input  1  halt flag of the current instruction from the decoder; sampled in the last stage.
- mem_req  input  1  current instruction needs memory; sampled while the MEM_STAGE enable is high.
- mem_ready  input  1  memory/MMIO accepts or completes the access.
- mem_valid  output  1  memory access request.
- stage_en  output  NUM_STAGES  one-hot stage enable.
- stage_idx  output  $clog2(NUM_STAGES)  index of the active stage.
- retire  output  1  instruction completes this cycle.
- halted  output  1  core halted.
- cycle_cnt  output  CNT_W  active cycle count.
- instret_cnt  output  CNT_W  retired instruction count.
- stall_cnt  output  CNT_W  memory stall cycle count.

Behaviour:
- Single clock domain; all state updates on posedge clk.
- rst=1 at a clock edge, including mid-instruction or mid-handshake, forces the following, effective next cycle:
  - state=IDLE, stage_en=0, stage_idx=0, retire=0, mem_valid=0, halted=0;
  - all counters=0.
- States: IDLE, RUN, WAIT_MEM, HALTED. stage_en and stage_idx are registered.
- IDLE:
  - stage_en=0.
  - If run=1, the next cycle has stage_en=1 (stage 0), state RUN.
  - If run=0, stay in IDLE.
- RUN:
  - Each cycle, stage_en shifts left by one and stage_idx increments by one.
  - Exception: at MEM_STAGE with mem_req=1, the sequencer enters WAIT_MEM and stage_en holds.
- WAIT_MEM:
  - mem_valid = stage_en[MEM_STAGE] & mem_req. It is combinational from registered state and inputs and has no path from mem_ready.
  - Once asserted, mem_valid stays high until a cycle with mem_ready=1.
  - In that cycle the transfer completes; next cycle advances to MEM_STAGE+1 in RUN.
  - mem_ready=1 in the first cycle gives zero stall, so the stage lasts 1 cycle, identical to mem_req=0.
  - mem_ready while mem_valid=0 is ignored.
- Last stage:
  - retire = stage_en[NUM_STAGES-1]; high exactly one cycle per instruction.
  - Next state is decided in that cycle:
    - is_halt=1 → HALTED (halt has priority over run);
    - else run=1 → stage 0 in RUN, i.e. back-to-back instructions with no bubble;
    - else → IDLE.
- run deasserted mid-instruction: the instruction completes normally, then the sequencer returns to IDLE.
- HALTED:
  - halted=1, stage_en=0, mem_valid=0.
  - Exit only via rst; run is ignored.
- Minimum latency: NUM_STAGES cycles per instruction, plus one cycle per memory wait cycle.
- Counters wrap modulo 2^CNT_W:
  - cycle_cnt increments in every RUN or WAIT_MEM cycle;
  - instret_cnt increments on retire;
  - stall_cnt increments when mem_valid & !mem_ready.

Optional Feature:
- Macro: STAGE_SEQ_PERF_CNT_EN.
- Defined: cycle_cnt, instret_cnt and stall_cnt are implemented as described above.
- Undefined: all three outputs are tied to 0 and no counter flops exist; all other behaviour is identical.

Decomposition:
- Shared package stage_seq_pkg holds:
  - enum seq_state_t {IDLE, RUN, WAIT_MEM, HALTED};
  - default parameter constants;
  - the MMIO addresses already in the global defines, reused by the core-level decode.
- One natural sub-module: stage_seq_perf. It holds the three counters, takes retire/active/stall strobes, and is instantiated only under STAGE_SEQ_PERF_CNT_EN.

Test Plan:
- Reset/start: rst=1 for 2 cycles, then rst=0, run=1, mem_req=0. Expect stage_en=00001 in the first cycle after leaving IDLE, then 00010 … 10000. retire is high only in the 5th cycle, then 00001 again.
- Memory stall: mem_req=1, mem_ready held low for 3 cycles, then high. Expect:
  - stage_en=01000 for 4 cycles and mem_valid high for 4 cycles;
  - stall_cnt=3 after the instruction;
  - instruction latency 8 cycles.
- Halt: is_halt=1 in the last stage with run=1. Expect retire=1 for that cycle, then halted=1, stage_en=0, permanently. run toggling has no effect until rst.
- Run drop: deassert run during stage 2. Expect the instruction to finish (retire once), then IDLE with stage_en=0. Reassert run: stage 0 starts next cycle.
- Reset mid-wait: rst=1 while mem_valid=1 and mem_ready=0. Expect all outputs at reset values next cycle, and counters 0.
- Parameters NUM_STAGES=3, MEM_STAGE=1, 10 instructions with the macro defined. Expect:
  - instret_cnt=10;
  - cycle_cnt = 30 + total stall cycles;
  - with CNT_W=4, counters wrap from 15 to 0.
